// File: rtl/rs232_tx_arbiter_if.sv
// Requester-side byte handshake plus transmitter-side control for the RS232 arbiter.
// Requesters: req_valid/req_ready per lane, a byte loads on the edge where both are 1.
interface rs232_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_lock;
    logic [NREQ-1:0]   req_ready;
    logic              cfg_fsel;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_fsel;
    logic              tx_rdy;
    logic              busy;
    logic [2:0]        grant_id;
    logic              locked;

    modport slave (
        input  req_valid, req_data, req_lock, cfg_fsel, tx_rdy,
        output req_ready, tx_start, tx_data, tx_fsel, busy, grant_id, locked
    );

    modport master (
        output req_valid, req_data, req_lock, cfg_fsel, tx_rdy,
        input  req_ready, tx_start, tx_data, tx_fsel, busy, grant_id, locked
    );
endinterface

// File: rtl/rs232_tx_arbiter.sv
// Round-robin arbiter sharing one RS232 byte transmitter between NREQ requesters,
// with per-requester line lock and an idle timeout that force-releases a stale lock.
module rs232_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int LOCK_IDLE = 4096
) (
    input  logic                clk,
    input  logic                rst,
    rs232_tx_arbiter_if.slave   bus,
    output logic [1:0]          fsm_state
);

    localparam int CW = $clog2(LOCK_IDLE + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAITLO = 2'd2,
        S_WAITHI = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [NREQ-1:0] hold_valid;
    logic [NREQ-1:0] hold_lock;
    logic [7:0]      hold_data [NREQ];
    logic [2:0]      rr_ptr;
    logic [2:0]      owner;
    logic [2:0]      grant_q;
    logic            locked_q;
    logic [CW-1:0]   lock_cnt;
    logic [7:0]      tx_data_q;
    logic            tx_fsel_q;

    logic            cand_found;
    logic [2:0]      cand_idx;
    logic [7:0]      cand_data;
    logic            grant_lock;
    logic            owner_full;
    logic            issue_go;
    int              scan_idx;

    // Winner search: walk from rr_ptr upward with wrap; smallest distance wins,
    // so the loop runs from the farthest slot down and lets nearer hits override.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = 3'd0;
        scan_idx   = 0;
        if (locked_q) begin
            for (int i = 0; i < NREQ; i++) begin
                if (owner == 3'(i) && hold_valid[i]) begin
                    cand_found = 1'b1;
                    cand_idx   = 3'(i);
                end
            end
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                scan_idx = int'(rr_ptr) + k;
                if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
                for (int i = 0; i < NREQ; i++) begin
                    if (scan_idx == i && hold_valid[i]) begin
                        cand_found = 1'b1;
                        cand_idx   = 3'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        cand_data  = 8'd0;
        grant_lock = 1'b0;
        owner_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (cand_idx == 3'(i)) cand_data = hold_data[i];
            if (grant_q == 3'(i))  grant_lock = hold_lock[i];
            if (owner == 3'(i))    owner_full = hold_valid[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // WAITLO never restarts the transmitter: any start there would reload its shifter.
    always_comb begin
        state_d  = state_q;
        issue_go = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.tx_rdy && cand_found) begin
                    issue_go = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE:  state_d = S_WAITLO;
            S_WAITLO: if (!bus.tx_rdy) state_d = S_WAITHI;
            S_WAITHI: if (bus.tx_rdy)  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Ready is low while full, so a load and the issue-clear never hit the same lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= '0;
            hold_lock  <= '0;
            for (int i = 0; i < NREQ; i++) hold_data[i] <= 8'd0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (state_q == S_ISSUE && grant_q == 3'(i)) begin
                    hold_valid[i] <= 1'b0;
                end else if (bus.req_valid[i] && !hold_valid[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_data[i]  <= bus.req_data[8*i +: 8];
                    hold_lock[i]  <= bus.req_lock[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q   <= 3'd0;
            rr_ptr    <= 3'd0;
            owner     <= 3'd0;
            locked_q  <= 1'b0;
            lock_cnt  <= '0;
            tx_data_q <= 8'd0;
            tx_fsel_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE) tx_fsel_q <= bus.cfg_fsel;
            if (issue_go) begin
                grant_q   <= cand_idx;
                tx_data_q <= cand_data;
            end
            if (state_q == S_ISSUE) begin
                rr_ptr   <= (grant_q == 3'(NREQ - 1)) ? 3'd0 : grant_q + 3'd1;
                locked_q <= grant_lock;
                owner    <= grant_q;
                lock_cnt <= '0;
            end else if (state_q == S_IDLE && locked_q && !owner_full) begin
                // Owner has gone quiet on an idle line: count toward force-release.
                if (lock_cnt == CW'(LOCK_IDLE - 1)) begin
                    locked_q <= 1'b0;
                    lock_cnt <= '0;
                end else begin
                    lock_cnt <= lock_cnt + CW'(1);
                end
            end
        end
    end

    assign bus.req_ready = ~hold_valid;
    assign bus.tx_start  = (state_q == S_ISSUE);
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_fsel   = tx_fsel_q;
    assign bus.busy      = (state_q != S_IDLE) || (|hold_valid);
    assign bus.grant_id  = grant_q;
    assign bus.locked    = locked_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Directed bench for rs232_tx_arbiter: requester drivers, a transmitter model with
// 20-cycle frames, and a scoreboard monitor that checks every tx_start.
module tb_rs232_tx_arbiter;
    localparam int NREQ      = 4;
    localparam int LOCK_IDLE = 8;
    localparam int FRAME     = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] fsm_state;

    rs232_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    rs232_tx_arbiter #(.NREQ(NREQ), .LOCK_IDLE(LOCK_IDLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    // Scoreboard entry: {grant_id[2:0], tx_data[7:0]}
    logic [10:0] exp_q[$];
    logic [10:0] mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Transmitter model: rdy drops on the edge after start, returns after FRAME cycles.
    logic tx_idle   = 1'b1;
    int   frame_cnt = 0;
    logic ext_busy  = 1'b0;
    assign bus.tx_rdy = tx_idle & ~ext_busy;

    always @(posedge clk) begin
        if (bus.tx_start && tx_idle) begin
            tx_idle   <= 1'b0;
            frame_cnt <= FRAME;
        end else if (!tx_idle) begin
            if (frame_cnt <= 1) tx_idle <= 1'b1;
            frame_cnt <= frame_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.tx_start === 1'b1) begin
            check("start_on_idle_line", 32'(tx_idle), 32'd1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_start: got data 0x%0h grant %0d, expected no start",
                         bus.tx_data, bus.grant_id);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_data", 32'(bus.tx_data), 32'(mon_e[7:0]));
                check("grant_id", 32'(bus.grant_id), 32'(mon_e[10:8]));
            end
        end
    end

    task automatic expect_byte(input int g, input logic [7:0] d);
        exp_q.push_back({3'(g), d});
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic lk);
        int n = 0;
        @(negedge clk);
        bus.req_data[8*i +: 8] = d;
        bus.req_lock[i]        = lk;
        bus.req_valid[i]       = 1'b1;
        while (bus.req_ready[i] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", 32'(n < 2000), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(fsm_state == 2'd0 && !bus.busy && exp_q.size() == 0 && bus.tx_rdy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(n < 3000), 32'd1);
    endtask

    task automatic wait_state(input logic [1:0] s);
        int n = 0;
        while (fsm_state !== s && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("state_reached", 32'(n < 500), 32'd1);
    endtask

    task automatic check_reset_values();
        check("rst_req_ready", 32'(bus.req_ready), 32'hF);
        check("rst_tx_start",  32'(bus.tx_start),  32'd0);
        check("rst_tx_data",   32'(bus.tx_data),   32'd0);
        check("rst_tx_fsel",   32'(bus.tx_fsel),   32'd0);
        check("rst_grant_id",  32'(bus.grant_id),  32'd0);
        check("rst_locked",    32'(bus.locked),    32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_fsm",       32'(fsm_state),     32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_lock  = '0;
        bus.cfg_fsel  = 1'b0;
        do_reset();

        // 1: single byte, two-cycle latency, ready back after ISSUE edge
        expect_byte(0, 8'h55);
        send(0, 8'h55, 1'b0);
        @(negedge clk);
        check("t1_no_start_on_decision", 32'(bus.tx_start), 32'd0);
        @(negedge clk);
        check("t1_start_latency", 32'(bus.tx_start), 32'd1);
        check("t1_ready_low_in_issue", 32'(bus.req_ready[0]), 32'd0);
        @(negedge clk);
        check("t1_ready_after_issue", 32'(bus.req_ready[0]), 32'd1);
        check("t1_start_one_cycle", 32'(bus.tx_start), 32'd0);
        wait_idle();

        // 2: simultaneous load after reset -> order 0,1,2,3
        do_reset();
        for (int i = 0; i < NREQ; i++) expect_byte(i, 8'hA0 + 8'(i));
        fork
            send(0, 8'hA0, 1'b0);
            send(1, 8'hA1, 1'b0);
            send(2, 8'hA2, 1'b0);
            send(3, 8'hA3, 1'b0);
        join
        wait_idle();

        // 3: fairness, req1 refills continuously, req2 loads once (pointer at 0)
        expect_byte(1, 8'hB0);
        expect_byte(2, 8'hC0);
        expect_byte(1, 8'hB1);
        expect_byte(1, 8'hB2);
        fork
            begin
                send(1, 8'hB0, 1'b0);
                send(1, 8'hB1, 1'b0);
                send(1, 8'hB2, 1'b0);
            end
            send(2, 8'hC0, 1'b0);
        join
        wait_idle();

        // 4: lock by req2 holds off req0 until the unlocking byte
        expect_byte(2, 8'h10);
        expect_byte(2, 8'h11);
        expect_byte(2, 8'h12);
        expect_byte(0, 8'hE0);
        send(2, 8'h10, 1'b1);
        send(0, 8'hE0, 1'b0);
        send(2, 8'h11, 1'b1);
        check("t4_locked_held", 32'(bus.locked), 32'd1);
        send(2, 8'h12, 1'b0);
        n = 0;
        while (bus.tx_start !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t4_start_seen", 32'(n < 500), 32'd1);
        check("t4_locked_in_issue", 32'(bus.locked), 32'd1);
        @(negedge clk);
        check("t4_unlock_after_issue", 32'(bus.locked), 32'd0);
        wait_idle();
        check("t4_locked_end", 32'(bus.locked), 32'd0);

        // 5: lock timeout after LOCK_IDLE idle cycles, then req1 issued
        expect_byte(3, 8'h33);
        expect_byte(1, 8'h77);
        send(3, 8'h33, 1'b1);
        send(1, 8'h77, 1'b0);
        wait_state(2'd3);
        check("t5_locked_in_frame", 32'(bus.locked), 32'd1);
        wait_state(2'd0);
        n = 0;
        while (fsm_state == 2'd0 && bus.locked && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("t5_lock_idle_cycles", 32'(n), 32'(LOCK_IDLE));
        wait_idle();

        // 6a: tx_rdy low in IDLE blocks issue
        expect_byte(0, 8'h42);
        ext_busy = 1'b1;
        send(0, 8'h42, 1'b0);
        repeat (6) @(negedge clk);
        check("t6_hold_while_tx_busy", 32'(fsm_state), 32'd0);
        check("t6_ready_low_pending", 32'(bus.req_ready[0]), 32'd0);
        ext_busy = 1'b0;
        wait_idle();

        // 6b: cfg_fsel change mid-frame only takes effect in IDLE
        expect_byte(1, 8'h66);
        send(1, 8'h66, 1'b0);
        wait_state(2'd3);
        bus.cfg_fsel = 1'b1;
        @(negedge clk);
        check("t6_fsel_stable_1", 32'(bus.tx_fsel), 32'd0);
        repeat (5) @(negedge clk);
        check("t6_fsel_stable_2", 32'(bus.tx_fsel), 32'd0);
        wait_idle();
        @(negedge clk);
        check("t6_fsel_in_idle", 32'(bus.tx_fsel), 32'd1);

        // 6c: async reset in WAITHI drops the pending byte
        expect_byte(2, 8'h99);
        send(2, 8'h99, 1'b0);
        wait_state(2'd3);
        send(3, 8'hAA, 1'b0);
        check("t6_pending_full", 32'(bus.req_ready[3]), 32'd0);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("t6_dropped_no_issue", 32'(bus.req_ready), 32'hF);
        check("t6_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
